rle_mem_writer: RTL and testbench

RLE_MEM_WRITER -- requirements
Module: rle_mem_writer

---
 rtl/app_pkg.sv | 16 +
 rtl/rle_wr_addr_ctr.sv | 38 +++
 rtl/rle_mem_writer.sv | 150 +++++++++++++++
 tb/tb_rle_mem_writer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/app_pkg.sv
// Shared definitions for the RLE memory writer and its read-side counterpart.
//   rle_state_t : control FSM state encoding (IDLE / WRITE / DONE)
//   *_W_DEF     : default address, data and repeat-count widths
package app_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } rle_state_t;

endpackage

// File: rtl/rle_wr_addr_ctr.sv
// Write pointer / word counter for the RLE memory writer.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset, pointer to 0
//   clear     : synchronous restart, pointer to 0
//   inc       : one word was written this cycle
//   count     : words written so far (0 .. 2**ADDR_W)
//   addr      : current write address (low bits of count)
//   full      : every address has been written
//   last_addr : pointer sits on the final address; the next write fills memory
module rle_wr_addr_ctr
  import app_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addr,
  output logic              full,
  output logic              last_addr
);

  // The extra MSB doubles as the full flag, so the pointer never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + 1'b1;
    end
  end

  assign full      = count[ADDR_W];
  assign addr      = count[ADDR_W-1:0];
  assign last_addr = !full && (&addr);

endmodule

// File: rtl/rle_mem_writer.sv
// Run-length decoder that expands (symbol, repeat) pairs into consecutive
// SRAM writes starting at address 0.
//   i_clk, i_reset      : clock and synchronous active-high reset
//   i_valid, o_ready    : pair handshake (ready only in IDLE)
//   i_data, i_repeats   : symbol and number of copies to write
//   i_last              : final pair of the stream
//   i_clear             : restart at address 0 from any state
//   o_done              : stream finished or memory full (held until clear)
//   o_overflow          : sticky, a write was dropped because memory was full
//   o_count             : words written since reset/clear
//   csb0, web0, addr0, din0 : SRAM write port (active-low selects)
module rle_mem_writer
  import app_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_repeats,
  input  logic              i_last,
  input  logic              i_clear,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_count,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0
);

  rle_state_t          state;
  logic [CNT_W-1:0]    rem_cnt;
  logic [CNT_W-1:0]    rem_next;
  logic                last_q;
  logic                ctr_inc;
  logic [ADDR_W-1:0]   ctr_addr;
  logic                ctr_full;
  logic                ctr_last_addr;

  // A write is on the port for every cycle spent in WRITE.
  assign ctr_inc  = (state == WRITE) && !i_clear;
  assign rem_next = rem_cnt - 1'b1;

  rle_wr_addr_ctr #(
    .ADDR_W (ADDR_W)
  ) u_addr_ctr (
    .clk       (i_clk),
    .reset     (i_reset),
    .clear     (i_clear),
    .inc       (ctr_inc),
    .count     (o_count),
    .addr      (ctr_addr),
    .full      (ctr_full),
    .last_addr (ctr_last_addr)
  );

  // SRAM port outputs are registered: the write for a cycle is set up on the
  // preceding edge, so the handshake edge already presents the first write.
  // din0 doubles as the latched symbol for the rest of the run.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      din0       <= '0;
      rem_cnt    <= '0;
      last_q     <= 1'b0;
    end else if (i_clear) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      csb0       <= 1'b1;
      web0       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            rem_cnt <= i_repeats;
            last_q  <= i_last;
            din0    <= i_data;
            if (ctr_full) begin
              o_overflow <= 1'b1;
              o_done     <= 1'b1;
              o_ready    <= 1'b0;
              state      <= DONE;
            end else if (i_repeats != '0) begin
              o_ready <= 1'b0;
              csb0    <= 1'b0;
              web0    <= 1'b0;
              addr0   <= ctr_addr;
              state   <= WRITE;
            end else if (i_last) begin
              o_done  <= 1'b1;
              o_ready <= 1'b0;
              state   <= DONE;
            end
          end
        end

        WRITE: begin
          rem_cnt <= rem_next;
          if ((rem_next != '0) && !ctr_last_addr) begin
            addr0 <= ctr_addr + 1'b1;
          end else begin
            csb0 <= 1'b1;
            web0 <= 1'b1;
            if (ctr_last_addr) begin
              // Memory fills with this write; anything still owed is dropped.
              o_done <= 1'b1;
              state  <= DONE;
              if ((rem_next != '0) || !last_q) begin
                o_overflow <= 1'b1;
              end
            end else if (last_q) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              o_ready <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        DONE: begin
          o_ready <= 1'b0;
          csb0    <= 1'b1;
          web0    <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          csb0    <= 1'b1;
          web0    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_mem_writer.sv
// Directed testbench for rle_mem_writer with a behavioural SRAM model.
module tb_rle_mem_writer;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_repeats;
  logic          i_last;
  logic          i_clear;
  logic          o_done;
  logic          o_overflow;
  logic [AW:0]   o_count;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;

  always #5 i_clk = ~i_clk;

  rle_mem_writer #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_repeats  (i_repeats),
    .i_last     (i_last),
    .i_clear    (i_clear),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .o_count    (o_count),
    .csb0       (csb0),
    .web0       (web0),
    .addr0      (addr0),
    .din0       (din0)
  );

  // SRAM model and event counters
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int unsigned   wr_total   = 0;
  int unsigned   hs_total   = 0;
  int unsigned   ready_viol = 0;

  always @(posedge i_clk) begin
    if (!csb0 && !web0) begin
      mem[addr0] <= din0;
      wr_total   <= wr_total + 1;
    end
    if (i_valid && o_ready) hs_total <= hs_total + 1;
  end

  always @(negedge i_clk) begin
    if (!csb0 && o_ready) ready_viol++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send_pair(input logic [DW-1:0] d, input logic [CW-1:0] r, input logic l);
    int unsigned guard = 0;
    i_valid   = 1'b1;
    i_data    = d;
    i_repeats = r;
    i_last    = l;
    while (!o_ready && guard < 1000) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) check_eq("send_timeout", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_settle();
    int unsigned guard = 0;
    while (!(o_ready || o_done) && guard < 1000) begin
      @(negedge i_clk);
      guard++;
    end
    if (!(o_ready || o_done)) check_eq("settle_timeout", {31'd0, o_ready | o_done}, 32'd1);
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
  endtask

  logic [DW-1:0] pd [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [CW-1:0] pr [4] = '{8'd2, 8'd0, 8'd1, 8'd3};
  logic          pl [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [DW-1:0] exp_q [$];

  initial begin
    int unsigned wr0;
    int unsigned hs0;
    int unsigned bad;
    int unsigned idx;
    int unsigned guard;

    i_reset = 1'b1; i_valid = 1'b0; i_data = '0; i_repeats = '0;
    i_last = 1'b0; i_clear = 1'b0;
    repeat (3) @(negedge i_clk);

    // Reset state
    check_eq("rst_csb0", {31'd0, csb0}, 32'd1);
    check_eq("rst_web0", {31'd0, web0}, 32'd1);
    check_eq("rst_addr0", {24'd0, addr0}, 32'd0);
    check_eq("rst_din0", {24'd0, din0}, 32'd0);
    check_eq("rst_done", {31'd0, o_done}, 32'd0);
    check_eq("rst_ovf", {31'd0, o_overflow}, 32'd0);
    check_eq("rst_count", {23'd0, o_count}, 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check_eq("rst_ready", {31'd0, o_ready}, 32'd1);

    // (AA,3),(55,2,last)
    wr0 = wr_total;
    send_pair(8'hAA, 8'd3, 1'b0);
    check_eq("lat_csb0", {31'd0, csb0}, 32'd0);
    check_eq("lat_web0", {31'd0, web0}, 32'd0);
    check_eq("lat_addr0", {24'd0, addr0}, 32'd0);
    check_eq("lat_din0", {24'd0, din0}, 32'h0000_00AA);
    check_eq("wr_ready_low", {31'd0, o_ready}, 32'd0);
    wait_settle();
    check_eq("p1_count", {23'd0, o_count}, 32'd3);
    send_pair(8'h55, 8'd2, 1'b1);
    wait_settle();
    check_eq("t1_mem0", {24'd0, mem[0]}, 32'hAA);
    check_eq("t1_mem1", {24'd0, mem[1]}, 32'hAA);
    check_eq("t1_mem2", {24'd0, mem[2]}, 32'hAA);
    check_eq("t1_mem3", {24'd0, mem[3]}, 32'h55);
    check_eq("t1_mem4", {24'd0, mem[4]}, 32'h55);
    check_eq("t1_count", {23'd0, o_count}, 32'd5);
    check_eq("t1_writes", wr_total - wr0, 32'd5);
    check_eq("t1_done", {31'd0, o_done}, 32'd1);
    check_eq("t1_ovf", {31'd0, o_overflow}, 32'd0);
    check_eq("t1_ready", {31'd0, o_ready}, 32'd0);

    // (11,0) then (22,1,last)
    pulse_clear();
    wr0 = wr_total;
    send_pair(8'h11, 8'd0, 1'b0);
    check_eq("zero_rep_ready", {31'd0, o_ready}, 32'd1);
    check_eq("zero_rep_csb0", {31'd0, csb0}, 32'd1);
    send_pair(8'h22, 8'd1, 1'b1);
    wait_settle();
    check_eq("t2_mem0", {24'd0, mem[0]}, 32'h22);
    check_eq("t2_count", {23'd0, o_count}, 32'd1);
    check_eq("t2_writes", wr_total - wr0, 32'd1);
    check_eq("t2_done", {31'd0, o_done}, 32'd1);

    // Clear out of DONE, then (77,1,last)
    pulse_clear();
    check_eq("clr_done", {31'd0, o_done}, 32'd0);
    check_eq("clr_count", {23'd0, o_count}, 32'd0);
    check_eq("clr_ready", {31'd0, o_ready}, 32'd1);
    send_pair(8'h77, 8'd1, 1'b1);
    wait_settle();
    check_eq("t3_mem0", {24'd0, mem[0]}, 32'h77);
    check_eq("t3_count", {23'd0, o_count}, 32'd1);

    // Fill memory: (01,255),(02,5,last)
    pulse_clear();
    wr0 = wr_total;
    send_pair(8'h01, 8'd255, 1'b0);
    wait_settle();
    check_eq("t4_mid_ready", {31'd0, o_ready}, 32'd1);
    check_eq("t4_mid_count", {23'd0, o_count}, 32'd255);
    send_pair(8'h02, 8'd5, 1'b1);
    wait_settle();
    repeat (3) @(negedge i_clk);
    bad = 0;
    for (int i = 0; i < 255; i++) if (mem[i] !== 8'h01) bad++;
    check_eq("t4_fill_bad", bad, 32'd0);
    check_eq("t4_mem255", {24'd0, mem[255]}, 32'h02);
    check_eq("t4_count", {23'd0, o_count}, 32'd256);
    check_eq("t4_writes", wr_total - wr0, 32'd256);
    check_eq("t4_ovf", {31'd0, o_overflow}, 32'd1);
    check_eq("t4_done", {31'd0, o_done}, 32'd1);
    check_eq("t4_csb0", {31'd0, csb0}, 32'd1);

    // Clear mid-WRITE
    pulse_clear();
    check_eq("clr_ovf", {31'd0, o_overflow}, 32'd0);
    send_pair(8'h44, 8'd5, 1'b0);
    @(negedge i_clk);
    pulse_clear();
    check_eq("cw_csb0", {31'd0, csb0}, 32'd1);
    check_eq("cw_count", {23'd0, o_count}, 32'd0);
    check_eq("cw_ready", {31'd0, o_ready}, 32'd1);

    // Reset during the 2nd write of (33,10)
    wr0 = wr_total;
    send_pair(8'h33, 8'd10, 1'b0);
    @(negedge i_clk);
    check_eq("rw_second_addr", {24'd0, addr0}, 32'd1);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check_eq("rw_csb0", {31'd0, csb0}, 32'd1);
    check_eq("rw_count", {23'd0, o_count}, 32'd0);
    check_eq("rw_ready", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    check_eq("rw_writes", wr_total - wr0, 32'd2);

    // i_valid held high over a stream of pairs
    wr0 = wr_total;
    hs0 = hs_total;
    exp_q.delete();
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < int'(pr[p]); j++) exp_q.push_back(pd[p]);
    idx = 0;
    guard = 0;
    i_valid = 1'b1;
    while (idx < 4 && guard < 200) begin
      i_data    = pd[idx];
      i_repeats = pr[idx];
      i_last    = pl[idx];
      if (o_ready) idx++;
      @(negedge i_clk);
      guard++;
    end
    check_eq("t5_accept_bound", idx, 32'd4);
    wait_settle();
    repeat (3) @(negedge i_clk);
    i_valid = 1'b0;
    check_eq("t5_handshakes", hs_total - hs0, 32'd4);
    check_eq("t5_writes", wr_total - wr0, exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (mem[i] !== exp_q[i]) bad++;
    check_eq("t5_scoreboard_bad", bad, 32'd0);
    check_eq("t5_count", {23'd0, o_count}, 32'd6);
    check_eq("t5_done", {31'd0, o_done}, 32'd1);
    check_eq("ready_during_write", ready_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
